// File: rtl/instr_sequencer_if.sv
// Host instruction port of the instruction sequencer: a packed instruction
// word offered with a valid/ready handshake.
interface instr_sequencer_if #(
  parameter int INSTR_W = 165
);

  logic [INSTR_W-1:0] instr_in;
  logic               instr_valid_in;
  logic               instr_ready_out;

  // Host side drives instructions and observes back-pressure
  modport master (
    output instr_in,
    output instr_valid_in,
    input  instr_ready_out
  );

  // Sequencer side accepts instructions and reports free space
  modport slave (
    input  instr_in,
    input  instr_valid_in,
    output instr_ready_out
  );

endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers packed control instructions in a FIFO and
// issues each one as registered single-cycle control pulses to the unified
// buffer, systolic array and VPU. Each instruction can repeat for up to
// 2^REP_W beats, and its first beat can be held back until a barrier pulse.
// Optional feature macro: SEQ_AUTO_INC_EN. When it is defined, beat k drives
// every write/read address as base+k (wrapping). When it is undefined, the
// addresses stay constant across beats and no beat counter is built.
module instr_sequencer #(
  parameter int N_LANES = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 7,
  parameter int DEPTH   = 8,
  parameter int REP_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  instr_sequencer_if.slave             host,
  input  logic                         stall_in,
  input  logic                         barrier_in,
  output logic                         busy_out,
  output logic                         waiting_out,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level_out,
  output logic                         sys_switch_in,
  output logic                         ub_rd_weight_transpose,
  output logic                         ub_rd_input_transpose,
  output logic                         ub_rd_weight_start_in,
  output logic                         ub_rd_input_start_in,
  output logic                         ub_rd_bias_start_in,
  output logic                         ub_rd_H_start_in,
  output logic                         ub_rd_Y_start_in,
  output logic                         ub_wr_addr_valid_in,
  output logic [N_LANES-1:0]           ub_wr_host_valid_in,
  output logic [N_LANES*DATA_W-1:0]    ub_wr_host_data_in,
  output logic [DATA_W-1:0]            inv_batch_size_times_two_in,
  output logic [DATA_W-1:0]            vpu_leak_factor_in,
  output logic [3:0]                   vpu_data_pathway,
  output logic [ADDR_W-1:0]            ub_rd_input_loc_in,
  output logic [ADDR_W-1:0]            ub_rd_weight_loc_in,
  output logic [ADDR_W-1:0]            ub_rd_bias_loc_in,
  output logic [ADDR_W-1:0]            ub_rd_H_loc_in,
  output logic [ADDR_W-1:0]            ub_rd_Y_loc_in,
  output logic [ADDR_W-1:0]            ub_wr_addr_in,
  output logic [ADDR_W-1:0]            ub_rd_input_addr_in,
  output logic [ADDR_W-1:0]            ub_rd_weight_addr_in,
  output logic [ADDR_W-1:0]            ub_rd_bias_addr_in,
  output logic [ADDR_W-1:0]            ub_rd_H_addr_in,
  output logic [ADDR_W-1:0]            ub_rd_Y_addr_in
);

  localparam int INSTR_W = 10 + N_LANES + (2 + N_LANES) * DATA_W + 4 + 11 * ADDR_W + REP_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = $clog2(DEPTH + 1);

  // Field offsets inside the packed instruction word (LSB first)
  localparam int WAIT_BIT = 9;
  localparam int HV_LO    = 10;
  localparam int INV_LO   = HV_LO + N_LANES;
  localparam int LEAK_LO  = INV_LO + DATA_W;
  localparam int PATH_LO  = LEAK_LO + DATA_W;
  localparam int HD_LO    = PATH_LO + 4;
  localparam int LOC_LO   = HD_LO + N_LANES * DATA_W;
  localparam int WRA_LO   = LOC_LO + 5 * ADDR_W;
  localparam int RDA_LO   = WRA_LO + ADDR_W;
  localparam int REP_LO   = RDA_LO + 5 * ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Sequencing state
  state_t             state;
  state_t             state_next;
  logic [REP_W-1:0]   remaining;
  logic [REP_W-1:0]   remaining_next;
  logic [INSTR_W-1:0] cur;
  logic               load_cur;
  logic [INSTR_W-1:0] head;
  logic               head_wait;
  logic [REP_W-1:0]   head_rep;
  logic [INSTR_W-1:0] sel;
  logic               issue;
  logic               first;
  logic [ADDR_W-1:0]  addr_off;
  logic               unused_sel_bits;

`ifdef SEQ_AUTO_INC_EN
  logic [REP_W-1:0]   beat;
  logic [REP_W-1:0]   beat_next;
`endif

  assign full                 = (level == LVL_W'(DEPTH));
  assign empty                = (level == '0);
  assign host.instr_ready_out = !full;
  assign push                 = host.instr_valid_in && !full;
  assign fifo_level_out       = level;

  assign head      = mem[rd_ptr];
  assign head_wait = head[WAIT_BIT];
  assign head_rep  = head[REP_LO +: REP_W];

  assign busy_out    = !empty || (state != IDLE);
  assign waiting_out = (state == WAIT);

  // Wait and repeat fields only steer the FSM, never the issued outputs
  assign unused_sel_bits = ^{sel[WAIT_BIT], sel[REP_LO +: REP_W]};

  // FIFO storage write; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= host.instr_in;
    end
  end

  // FIFO pointers and occupancy; a same-cycle push and pop cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sequencer state register: FSM state, beats left and the repeating instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      cur       <= '0;
`ifdef SEQ_AUTO_INC_EN
      beat      <= '0;
`endif
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      if (load_cur) cur <= head;
`ifdef SEQ_AUTO_INC_EN
      beat      <= beat_next;
`endif
    end
  end

  // Next-state and issue decision; beat 0 comes from the FIFO head, later beats from cur
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    issue          = 1'b0;
    pop            = 1'b0;
    first          = 1'b0;
    load_cur       = 1'b0;
    sel            = head;
`ifdef SEQ_AUTO_INC_EN
    beat_next      = beat;
`endif
    case (state)
      IDLE, WAIT: begin
        if (!empty) begin
          if (head_wait && !barrier_in) begin
            state_next = WAIT;
          end else if (!stall_in) begin
            issue = 1'b1;
            pop   = 1'b1;
            first = 1'b1;
`ifdef SEQ_AUTO_INC_EN
            beat_next = REP_W'(1);
`endif
            if (head_rep != '0) begin
              state_next     = RPT;
              remaining_next = head_rep;
              load_cur       = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      RPT: begin
        sel = cur;
        if (!stall_in) begin
          issue          = 1'b1;
          remaining_next = remaining - REP_W'(1);
`ifdef SEQ_AUTO_INC_EN
          beat_next      = beat + REP_W'(1);
`endif
          if (remaining == REP_W'(1)) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address offset for the beat being issued
  always_comb begin
`ifdef SEQ_AUTO_INC_EN
    addr_off = first ? '0 : ADDR_W'(beat);
`else
    addr_off = '0;
`endif
  end

  // Registered datapath controls: pulses only on issue, sticky config on beat 0, addresses hold
  always_ff @(posedge clk) begin
    if (rst) begin
      sys_switch_in               <= 1'b0;
      ub_rd_weight_transpose      <= 1'b0;
      ub_rd_weight_start_in       <= 1'b0;
      ub_rd_input_transpose       <= 1'b0;
      ub_rd_input_start_in        <= 1'b0;
      ub_rd_bias_start_in         <= 1'b0;
      ub_rd_H_start_in            <= 1'b0;
      ub_rd_Y_start_in            <= 1'b0;
      ub_wr_addr_valid_in         <= 1'b0;
      ub_wr_host_valid_in         <= '0;
      ub_wr_host_data_in          <= '0;
      inv_batch_size_times_two_in <= '0;
      vpu_leak_factor_in          <= '0;
      vpu_data_pathway            <= '0;
      ub_rd_input_loc_in          <= '0;
      ub_rd_weight_loc_in         <= '0;
      ub_rd_bias_loc_in           <= '0;
      ub_rd_H_loc_in              <= '0;
      ub_rd_Y_loc_in              <= '0;
      ub_wr_addr_in               <= '0;
      ub_rd_input_addr_in         <= '0;
      ub_rd_weight_addr_in        <= '0;
      ub_rd_bias_addr_in          <= '0;
      ub_rd_H_addr_in             <= '0;
      ub_rd_Y_addr_in             <= '0;
    end else begin
      sys_switch_in          <= issue && sel[0];
      ub_rd_weight_transpose <= issue && sel[1];
      ub_rd_weight_start_in  <= issue && sel[2];
      ub_rd_input_transpose  <= issue && sel[3];
      ub_rd_input_start_in   <= issue && sel[4];
      ub_rd_bias_start_in    <= issue && sel[5];
      ub_rd_H_start_in       <= issue && sel[6];
      ub_rd_Y_start_in       <= issue && sel[7];
      ub_wr_addr_valid_in    <= issue && sel[8];
      ub_wr_host_valid_in    <= issue ? sel[HV_LO +: N_LANES] : '0;
      ub_wr_host_data_in     <= issue ? sel[HD_LO +: N_LANES*DATA_W] : '0;
      if (issue && first) begin
        inv_batch_size_times_two_in <= sel[INV_LO +: DATA_W];
        vpu_leak_factor_in          <= sel[LEAK_LO +: DATA_W];
        vpu_data_pathway            <= sel[PATH_LO +: 4];
      end
      if (issue) begin
        ub_rd_input_loc_in   <= sel[LOC_LO + 0*ADDR_W +: ADDR_W];
        ub_rd_weight_loc_in  <= sel[LOC_LO + 1*ADDR_W +: ADDR_W];
        ub_rd_bias_loc_in    <= sel[LOC_LO + 2*ADDR_W +: ADDR_W];
        ub_rd_H_loc_in       <= sel[LOC_LO + 3*ADDR_W +: ADDR_W];
        ub_rd_Y_loc_in       <= sel[LOC_LO + 4*ADDR_W +: ADDR_W];
        ub_wr_addr_in        <= sel[WRA_LO +: ADDR_W] + addr_off;
        ub_rd_input_addr_in  <= sel[RDA_LO + 0*ADDR_W +: ADDR_W] + addr_off;
        ub_rd_weight_addr_in <= sel[RDA_LO + 1*ADDR_W +: ADDR_W] + addr_off;
        ub_rd_bias_addr_in   <= sel[RDA_LO + 2*ADDR_W +: ADDR_W] + addr_off;
        ub_rd_H_addr_in      <= sel[RDA_LO + 3*ADDR_W +: ADDR_W] + addr_off;
        ub_rd_Y_addr_in      <= sel[RDA_LO + 4*ADDR_W +: ADDR_W] + addr_off;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer (default parameters). Expected
// addresses follow SEQ_AUTO_INC_EN when the bundle is built with it.
module tb_instr_sequencer;

  localparam int N_LANES = 2;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 7;
  localparam int DEPTH   = 8;
  localparam int REP_W   = 8;
  localparam int INSTR_W = 165;

`ifdef SEQ_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  // Instruction layout written out field by field (last member = bit 0)
  typedef struct packed {
    logic [7:0]  rpt;
    logic [6:0]  rd_y;
    logic [6:0]  rd_h;
    logic [6:0]  rd_bias;
    logic [6:0]  rd_weight;
    logic [6:0]  rd_input;
    logic [6:0]  wr_addr;
    logic [6:0]  loc_y;
    logic [6:0]  loc_h;
    logic [6:0]  loc_bias;
    logic [6:0]  loc_weight;
    logic [6:0]  loc_input;
    logic [31:0] host_data;
    logic [3:0]  pathway;
    logic [15:0] leak;
    logic [15:0] inv_batch;
    logic [1:0]  host_valid;
    logic        wait_b;
    logic        wr_addr_valid;
    logic        y_start;
    logic        h_start;
    logic        bias_start;
    logic        i_start;
    logic        i_transpose;
    logic        w_start;
    logic        w_transpose;
    logic        sys_switch;
  } instr_t;

  logic clk = 1'b0;
  logic rst;
  logic stall_in;
  logic barrier_in;
  logic busy_out;
  logic waiting_out;
  logic [3:0]  fifo_level_out;
  logic sys_switch_in, ub_rd_weight_transpose, ub_rd_input_transpose;
  logic ub_rd_weight_start_in, ub_rd_input_start_in, ub_rd_bias_start_in;
  logic ub_rd_H_start_in, ub_rd_Y_start_in, ub_wr_addr_valid_in;
  logic [1:0]  ub_wr_host_valid_in;
  logic [31:0] ub_wr_host_data_in;
  logic [15:0] inv_batch_size_times_two_in;
  logic [15:0] vpu_leak_factor_in;
  logic [3:0]  vpu_data_pathway;
  logic [6:0]  ub_rd_input_loc_in, ub_rd_weight_loc_in, ub_rd_bias_loc_in;
  logic [6:0]  ub_rd_H_loc_in, ub_rd_Y_loc_in;
  logic [6:0]  ub_wr_addr_in, ub_rd_input_addr_in, ub_rd_weight_addr_in;
  logic [6:0]  ub_rd_bias_addr_in, ub_rd_H_addr_in, ub_rd_Y_addr_in;

  int n_cmp = 0;
  int n_err = 0;

  instr_sequencer_if #(.INSTR_W(INSTR_W)) bus ();

  instr_sequencer #(
    .N_LANES(N_LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .REP_W(REP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host(bus),
    .stall_in(stall_in),
    .barrier_in(barrier_in),
    .busy_out(busy_out),
    .waiting_out(waiting_out),
    .fifo_level_out(fifo_level_out),
    .sys_switch_in(sys_switch_in),
    .ub_rd_weight_transpose(ub_rd_weight_transpose),
    .ub_rd_input_transpose(ub_rd_input_transpose),
    .ub_rd_weight_start_in(ub_rd_weight_start_in),
    .ub_rd_input_start_in(ub_rd_input_start_in),
    .ub_rd_bias_start_in(ub_rd_bias_start_in),
    .ub_rd_H_start_in(ub_rd_H_start_in),
    .ub_rd_Y_start_in(ub_rd_Y_start_in),
    .ub_wr_addr_valid_in(ub_wr_addr_valid_in),
    .ub_wr_host_valid_in(ub_wr_host_valid_in),
    .ub_wr_host_data_in(ub_wr_host_data_in),
    .inv_batch_size_times_two_in(inv_batch_size_times_two_in),
    .vpu_leak_factor_in(vpu_leak_factor_in),
    .vpu_data_pathway(vpu_data_pathway),
    .ub_rd_input_loc_in(ub_rd_input_loc_in),
    .ub_rd_weight_loc_in(ub_rd_weight_loc_in),
    .ub_rd_bias_loc_in(ub_rd_bias_loc_in),
    .ub_rd_H_loc_in(ub_rd_H_loc_in),
    .ub_rd_Y_loc_in(ub_rd_Y_loc_in),
    .ub_wr_addr_in(ub_wr_addr_in),
    .ub_rd_input_addr_in(ub_rd_input_addr_in),
    .ub_rd_weight_addr_in(ub_rd_weight_addr_in),
    .ub_rd_bias_addr_in(ub_rd_bias_addr_in),
    .ub_rd_H_addr_in(ub_rd_H_addr_in),
    .ub_rd_Y_addr_in(ub_rd_Y_addr_in)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Drive all host-side inputs for the next active edge
  task automatic applyStimulus(input instr_t ins, input logic valid, input logic stall,
                               input logic barrier);
    bus.instr_in       = ins;
    bus.instr_valid_in = valid;
    stall_in           = stall;
    barrier_in         = barrier;
  endtask

  // Advance one cycle and settle just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Address expected on beat k for a given base
  function automatic logic [6:0] expAddr(input logic [6:0] base, input int k);
    logic [6:0] off;
    off = 7'(k);
    return AUTO_INC ? (base + off) : base;
  endfunction

  instr_t ins;
  int     pulses;

  initial begin
    ins = '0;
    rst = 1'b1;
    applyStimulus(ins, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_ready", bus.instr_ready_out, 1);
    checkOutput("rst_busy", busy_out, 0);
    checkOutput("rst_level", fifo_level_out, 0);
    checkOutput("rst_waiting", waiting_out, 0);
    checkOutput("rst_istart", ub_rd_input_start_in, 0);
    checkOutput("rst_leak", vpu_leak_factor_in, 0);
    checkOutput("rst_rdaddr", ub_rd_input_addr_in, 0);
    rst = 1'b0;

    // Single instruction: one i_start pulse with address 5
    ins = '0;
    ins.i_start  = 1'b1;
    ins.rd_input = 7'd5;
    applyStimulus(ins, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(ins, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_level_after_push", fifo_level_out, 1);
    checkOutput("t1_no_early_pulse", ub_rd_input_start_in, 0);
    checkOutput("t1_busy", busy_out, 1);
    tick();
    checkOutput("t1_istart", ub_rd_input_start_in, 1);
    checkOutput("t1_addr", ub_rd_input_addr_in, 5);
    checkOutput("t1_level_popped", fifo_level_out, 0);
    tick();
    checkOutput("t1_istart_off", ub_rd_input_start_in, 0);
    checkOutput("t1_addr_hold", ub_rd_input_addr_in, 5);
    checkOutput("t1_busy_off", busy_out, 0);

    // Fill the FIFO under stall, reject a 9th, then drain back-to-back
    for (int i = 0; i < 8; i++) begin
      ins = '0;
      ins.i_start    = 1'b1;
      ins.rd_input   = 7'(10 + i);
      ins.host_valid = 2'b01;
      ins.host_data  = 32'hA5A5_0000 + 32'(i);
      applyStimulus(ins, 1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("t2_level_full", fifo_level_out, 8);
    checkOutput("t2_ready_low", bus.instr_ready_out, 0);
    ins = '0;
    ins.i_start  = 1'b1;
    ins.rd_input = 7'd99;
    applyStimulus(ins, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("t2_ninth_rejected", fifo_level_out, 8);
    checkOutput("t2_stalled_no_pulse", ub_rd_input_start_in, 0);
    applyStimulus(ins, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("t2_drain_istart%0d", k), ub_rd_input_start_in, 1);
      checkOutput($sformatf("t2_drain_addr%0d", k), ub_rd_input_addr_in, 64'(10 + k));
      checkOutput($sformatf("t2_drain_hdata%0d", k), ub_wr_host_data_in,
                  64'(32'hA5A5_0000 + 32'(k)));
      checkOutput($sformatf("t2_drain_level%0d", k), fifo_level_out, 64'(7 - k));
    end
    tick();
    checkOutput("t2_drained_idle", ub_rd_input_start_in, 0);
    checkOutput("t2_hvalid_off", ub_wr_host_valid_in, 0);
    checkOutput("t2_busy_off", busy_out, 0);

    // Repeat 3 with wrap-around of the write address
    ins = '0;
    ins.wr_addr_valid = 1'b1;
    ins.wr_addr       = 7'd126;
    ins.rd_input      = 7'd3;
    ins.loc_input     = 7'd9;
    ins.rpt           = 8'd3;
    applyStimulus(ins, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(ins, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("t3_wvalid%0d", k), ub_wr_addr_valid_in, 1);
      checkOutput($sformatf("t3_wraddr%0d", k), ub_wr_addr_in, 64'(expAddr(7'd126, k)));
      checkOutput($sformatf("t3_rdaddr%0d", k), ub_rd_input_addr_in, 64'(expAddr(7'd3, k)));
      checkOutput($sformatf("t3_loc%0d", k), ub_rd_input_loc_in, 9);
    end
    tick();
    checkOutput("t3_done_wvalid", ub_wr_addr_valid_in, 0);
    checkOutput("t3_done_busy", busy_out, 0);

    // Barrier-gated head
    ins = '0;
    ins.wait_b  = 1'b1;
    ins.y_start = 1'b1;
    ins.rd_y    = 7'd44;
    applyStimulus(ins, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(ins, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("t4_waiting%0d", k), waiting_out, 1);
      checkOutput($sformatf("t4_no_pulse%0d", k), ub_rd_Y_start_in, 0);
    end
    applyStimulus(ins, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t4_released_pulse", ub_rd_Y_start_in, 1);
    checkOutput("t4_released_addr", ub_rd_Y_addr_in, 44);
    checkOutput("t4_released_waiting", waiting_out, 0);
    applyStimulus(ins, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t4_pulse_off", ub_rd_Y_start_in, 0);
    checkOutput("t4_busy_off", busy_out, 0);
    applyStimulus(ins, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t4_idle_barrier_busy", busy_out, 0);
    checkOutput("t4_idle_barrier_pulse", ub_rd_Y_start_in, 0);
    checkOutput("t4_idle_barrier_wait", waiting_out, 0);

    // Stall in the middle of a repeat-4 instruction
    ins = '0;
    ins.h_start   = 1'b1;
    ins.rd_h      = 7'd20;
    ins.leak      = 16'h1234;
    ins.inv_batch = 16'h0042;
    ins.pathway   = 4'hA;
    ins.rpt       = 8'd4;
    pulses = 0;
    applyStimulus(ins, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(ins, 1'b0, 1'b0, 1'b0);
    tick();
    pulses += int'(ub_rd_H_start_in);
    checkOutput("t5_b0_addr", ub_rd_H_addr_in, 64'(expAddr(7'd20, 0)));
    checkOutput("t5_b0_leak", vpu_leak_factor_in, 16'h1234);
    checkOutput("t5_b0_inv", inv_batch_size_times_two_in, 16'h0042);
    checkOutput("t5_b0_path", vpu_data_pathway, 4'hA);
    tick();
    pulses += int'(ub_rd_H_start_in);
    checkOutput("t5_b1_addr", ub_rd_H_addr_in, 64'(expAddr(7'd20, 1)));
    applyStimulus(ins, 1'b0, 1'b1, 1'b0);
    tick();
    pulses += int'(ub_rd_H_start_in);
    checkOutput("t5_stall_pulse", ub_rd_H_start_in, 0);
    checkOutput("t5_stall_addr_hold", ub_rd_H_addr_in, 64'(expAddr(7'd20, 1)));
    tick();
    pulses += int'(ub_rd_H_start_in);
    checkOutput("t5_stall2_pulse", ub_rd_H_start_in, 0);
    applyStimulus(ins, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k < 5; k++) begin
      tick();
      pulses += int'(ub_rd_H_start_in);
      checkOutput($sformatf("t5_b%0d_pulse", k), ub_rd_H_start_in, 1);
      checkOutput($sformatf("t5_b%0d_addr", k), ub_rd_H_addr_in, 64'(expAddr(7'd20, k)));
    end
    tick();
    pulses += int'(ub_rd_H_start_in);
    checkOutput("t5_pulse_count", pulses, 5);
    checkOutput("t5_leak_kept", vpu_leak_factor_in, 16'h1234);
    checkOutput("t5_busy_off", busy_out, 0);

    // Reset in the middle of a repeat with entries still queued
    ins = '0;
    ins.bias_start = 1'b1;
    ins.rd_bias    = 7'd40;
    ins.rpt        = 8'd5;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ins, 1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("t6_level_queued", fifo_level_out, 4);
    applyStimulus(ins, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t6_b0_pulse", ub_rd_bias_start_in, 1);
    checkOutput("t6_b0_level", fifo_level_out, 3);
    tick();
    checkOutput("t6_b1_pulse", ub_rd_bias_start_in, 1);
    rst = 1'b1;
    tick();
    checkOutput("t6_rst_level", fifo_level_out, 0);
    checkOutput("t6_rst_pulse", ub_rd_bias_start_in, 0);
    checkOutput("t6_rst_addr", ub_rd_bias_addr_in, 0);
    checkOutput("t6_rst_busy", busy_out, 0);
    checkOutput("t6_rst_ready", bus.instr_ready_out, 1);
    checkOutput("t6_rst_leak", vpu_leak_factor_in, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("t6_post_pulse%0d", k), ub_rd_bias_start_in, 0);
      checkOutput($sformatf("t6_post_busy%0d", k), busy_out, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
